// File: rtl/full_adder_1b_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : full_adder_1b_pkg                                         |
// | Brief    : Shared types and helpers for the 1-bit full adder and its |
// |            bit-serial wrapper.                                       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package full_adder_1b_pkg;

  // Serial controller states; one bit is enough for two states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Counter width able to hold the values 0..w inclusive
  function automatic int cnt_width(input int w);
    return (w < 1) ? 1 : $clog2(w + 1);
  endfunction

  // Majority of three inputs: the carry of a full adder
  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage : full_adder_1b_pkg
`default_nettype wire

// File: rtl/full_adder_1b_cell.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : full_adder_1b_cell                                        |
// | Brief    : Pure combinational 1-bit full adder leaf cell.            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module full_adder_1b_cell
  import full_adder_1b_pkg::*;
(
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  // Sum is odd parity of the three inputs, carry is their majority
  always_comb begin
    o_s    = i_a ^ i_b ^ i_cin;
    o_cout = maj(i_a, i_b, i_cin);
  end

endmodule : full_adder_1b_cell
`default_nettype wire

// File: rtl/full_adder_1b.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : full_adder_1b                                             |
// | Brief    : 1-bit full adder with a combinational path plus a         |
// |            bit-serial W-bit adder (LSB first) built on the same cell.|
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module full_adder_1b
  import full_adder_1b_pkg::*;
#(
  parameter int W = 8
)(
  input  logic         clk,
  input  logic         rst,      // asynchronous, active low
  input  logic         a,
  input  logic         b,
  input  logic         cin,
  output logic         s,
  output logic         cout,
  input  logic         start,
  input  logic         en,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum_q,
  output logic         carry_q
);

  localparam int c_cnt_w = cnt_width(W);

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [W-1:0]         r_sum;
  logic                 r_carry;
  logic                 r_done;

  logic                 w_carry_in;
  logic                 w_ser_s;
  logic                 w_ser_c;
  logic                 w_last_bit;

  // Combinational adder on the raw inputs
  full_adder_1b_cell u_comb_cell (
    .i_a    (a),
    .i_b    (b),
    .i_cin  (cin),
    .o_s    (s),
    .o_cout (cout)
  );

  // A start seeds the chain from cin; otherwise the stored carry ripples in
  always_comb begin
    w_carry_in = start ? cin : r_carry;
    w_last_bit = (r_cnt == c_cnt_w'(W - 1));
  end

  // Serial datapath cell on the same operand bits
  full_adder_1b_cell u_ser_cell (
    .i_a    (a),
    .i_b    (b),
    .i_cin  (w_carry_in),
    .o_s    (w_ser_s),
    .o_cout (w_ser_c)
  );

  // Serial controller: accepts bit 0 on start, then one bit per enabled edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (en) begin
        if (start) begin
          // New addition (also aborts one in progress): only bit 0 survives
          r_sum    <= '0;
          r_sum[0] <= w_ser_s;
          r_carry  <= w_ser_c;
          r_cnt    <= c_cnt_w'(1);
          if (W == 1) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_RUN;
          end
        end else if (r_state == ST_RUN) begin
          for (int i = 0; i < W; i++) begin
            if (r_cnt == c_cnt_w'(i)) begin
              r_sum[i] <= w_ser_s;
            end
          end
          r_carry <= w_ser_c;
          r_cnt   <= r_cnt + c_cnt_w'(1);
          if (w_last_bit) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
      end
    end
  end

  // Registered status and results straight to the ports
  always_comb begin
    busy    = (r_state == ST_RUN);
    done    = r_done;
    sum_q   = r_sum;
    carry_q = r_carry;
  end

endmodule : full_adder_1b
`default_nettype wire

// File: tb/tb_full_adder_1b.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_full_adder_1b                                          |
// | Brief    : Directed self-checking bench for full_adder_1b (W = 8).   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_full_adder_1b;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         a, b, cin;
  logic         s, cout;
  logic         start, en;
  logic         busy, done;
  logic [W-1:0] sum_q;
  logic         carry_q;

  int n_vec;
  int n_err;

  full_adder_1b #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .s       (s),
    .cout    (cout),
    .start   (start),
    .en      (en),
    .busy    (busy),
    .done    (done),
    .sum_q   (sum_q),
    .carry_q (carry_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, landing 1 ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full serial addition with an optional stall before bit stall_at
  task automatic run_add(input logic [7:0] opa, input logic [7:0] opb, input logic c,
                         input int stall_at, input int stall_len,
                         input logic [7:0] exp_sum, input logic exp_carry,
                         input int exp_lat, input string tag);
    int lat;
    start = 1'b1; en = 1'b1; a = opa[0]; b = opb[0]; cin = c;
    tick();
    lat = 1;
    start = 1'b0; cin = 1'b0;
    for (int k = 1; k < W; k++) begin
      if (k == stall_at) begin
        en = 1'b0;
        for (int j = 0; j < stall_len; j++) begin
          a = ~a; b = ~b;
          tick();
          lat++;
          chk({tag, "_stall_busy"}, 32'(busy), 32'd1);
        end
        en = 1'b1;
      end
      chk({tag, "_nodone"}, 32'(done), 32'd0);
      a = opa[k]; b = opb[k];
      tick();
      lat++;
    end
    en = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_sum"}, 32'(sum_q), 32'(exp_sum));
    chk({tag, "_carry"}, 32'(carry_q), 32'(exp_carry));
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_hold"}, 32'(sum_q), 32'(exp_sum));
  endtask

  initial begin
    logic [1:0] tab [8];
    logic [7:0] opa, opb;
    int unsigned exp2;

    n_vec = 0; n_err = 0;
    rst = 1'b0; a = 0; b = 0; cin = 0; start = 0; en = 0;
    tab = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

    // Reset state
    tick();
    chk("rst_busy",  32'(busy),    32'd0);
    chk("rst_done",  32'(done),    32'd0);
    chk("rst_sum",   32'(sum_q),   32'd0);
    chk("rst_carry", 32'(carry_q), 32'd0);
    rst = 1'b1;
    tick();

    // Exhaustive combinational truth table; index is {a,b,cin}
    for (int i = 0; i < 8; i++) begin
      {a, b, cin} = 3'(i);
      #1;
      chk("comb_tab", 32'({cout, s}), 32'(tab[i]));
    end

    // Random combinational sweep
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      a = 1'($urandom); b = 1'($urandom); cin = 1'($urandom);
      @(negedge clk);
      exp2 = 32'(a) + 32'(b) + 32'(cin);
      chk("comb_rand", 32'({cout, s}), exp2);
    end
    #1;

    // Plain serial additions
    run_add(8'hA5, 8'h3C, 1'b0, 0, 0, 8'hE1, 1'b0, 8,  "add_a5_3c");
    run_add(8'hFF, 8'h01, 1'b0, 0, 0, 8'h00, 1'b1, 8,  "add_ff_01");
    // Three-cycle stall mid-stream
    run_add(8'hA5, 8'h3C, 1'b0, 4, 3, 8'hE1, 1'b0, 11, "stall");

    // Start without enable is ignored
    start = 1'b1; en = 1'b0; a = 1; b = 0;
    tick();
    chk("start_noen_busy", 32'(busy),  32'd0);
    chk("start_noen_sum",  32'(sum_q), 32'hE1);
    start = 1'b0;

    // Asynchronous reset after four bits, between clock edges
    opa = 8'hA5; opb = 8'h3C;
    start = 1'b1; en = 1'b1; a = opa[0]; b = opb[0]; cin = 0;
    tick();
    start = 1'b0;
    for (int k = 1; k < 4; k++) begin
      a = opa[k]; b = opb[k];
      tick();
    end
    chk("pre_arst_busy", 32'(busy), 32'd1);
    en = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_busy",  32'(busy),    32'd0);
    chk("arst_sum",   32'(sum_q),   32'd0);
    chk("arst_carry", 32'(carry_q), 32'd0);
    chk("arst_done",  32'(done),    32'd0);
    tick();
    rst = 1'b1;
    run_add(8'h01, 8'h01, 1'b0, 0, 0, 8'h02, 1'b0, 8, "post_rst");

    // Restart at bit 5 of an addition of 0xFF + 0xFF
    opa = 8'hFF; opb = 8'hFF;
    start = 1'b1; en = 1'b1; a = opa[0]; b = opb[0]; cin = 1'b1;
    tick();
    start = 1'b0; cin = 1'b0;
    for (int k = 1; k < 5; k++) begin
      a = opa[k]; b = opb[k];
      tick();
    end
    opa = 8'h10; opb = 8'h20;
    start = 1'b1; a = opa[0]; b = opb[0]; cin = 1'b1;
    tick();
    start = 1'b0; cin = 1'b0;
    chk("restart_sum0",  32'(sum_q),   32'h01);
    chk("restart_carry", 32'(carry_q), 32'd0);
    chk("restart_busy",  32'(busy),    32'd1);
    for (int k = 1; k < W; k++) begin
      chk("restart_nodone", 32'(done), 32'd0);
      a = opa[k]; b = opb[k];
      tick();
    end
    en = 1'b0;
    chk("restart_done",  32'(done),    32'd1);
    chk("restart_sum",   32'(sum_q),   32'h31);
    chk("restart_cout",  32'(carry_q), 32'd0);
    tick();
    chk("restart_pulse", 32'(done),    32'd0);

    // Restart on the edge that would complete: restart wins, no done
    opa = 8'h00; opb = 8'h00;
    start = 1'b1; en = 1'b1; a = 0; b = 0; cin = 0;
    tick();
    start = 1'b0;
    for (int k = 1; k < W - 1; k++) begin
      tick();
    end
    start = 1'b1; a = 1; b = 1; cin = 1;
    tick();
    start = 1'b0; en = 1'b0; cin = 0;
    chk("late_restart_done", 32'(done),    32'd0);
    chk("late_restart_busy", 32'(busy),    32'd1);
    chk("late_restart_sum",  32'(sum_q),   32'h01);
    chk("late_restart_cry",  32'(carry_q), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_full_adder_1b
`default_nettype wire
